// File: rtl/term_cmd_pkg.sv
// Shared constants for the terminal command decoder: command indices,
// command text table, ASCII control codes and FSM state encoding.
package term_cmd_pkg;

  localparam int unsigned CMD_NUM   = 11;
  localparam int unsigned TXT_BYTES = 8;

  // Bit index of each command inside op_code
  localparam int unsigned CMD_CLEAR = 0;
  localparam int unsigned CMD_HELP  = 1;
  localparam int unsigned CMD_LED   = 2;
  localparam int unsigned CMD_TIME  = 3;
  localparam int unsigned CMD_SIREN = 4;
  localparam int unsigned CMD_STOP  = 5;
  localparam int unsigned CMD_RED   = 6;
  localparam int unsigned CMD_GREEN = 7;
  localparam int unsigned CMD_BLUE  = 8;
  localparam int unsigned CMD_ECHO  = 9;
  localparam int unsigned CMD_RESET = 10;

  // ASCII control codes
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_DEL = 8'h7F;

  // Command text, first character in the top byte, zero padded to 8 bytes
  localparam logic [63:0] TXT_CLEAR = {"clear", 24'h0};
  localparam logic [63:0] TXT_HELP  = {"help",  32'h0};
  localparam logic [63:0] TXT_LED   = {"led",   40'h0};
  localparam logic [63:0] TXT_TIME  = {"time",  32'h0};
  localparam logic [63:0] TXT_SIREN = {"siren", 24'h0};
  localparam logic [63:0] TXT_STOP  = {"stop",  32'h0};
  localparam logic [63:0] TXT_RED   = {"red",   40'h0};
  localparam logic [63:0] TXT_GREEN = {"green", 24'h0};
  localparam logic [63:0] TXT_BLUE  = {"blue",  32'h0};
  localparam logic [63:0] TXT_ECHO  = {"echo",  32'h0};
  localparam logic [63:0] TXT_RESET = {"reset", 24'h0};

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_MATCH   = 2'd1,
    ST_ISSUE   = 2'd2
  } state_e;

  function automatic logic [63:0] cmd_text(input int unsigned idx);
    case (idx)
      CMD_CLEAR: return TXT_CLEAR;
      CMD_HELP:  return TXT_HELP;
      CMD_LED:   return TXT_LED;
      CMD_TIME:  return TXT_TIME;
      CMD_SIREN: return TXT_SIREN;
      CMD_STOP:  return TXT_STOP;
      CMD_RED:   return TXT_RED;
      CMD_GREEN: return TXT_GREEN;
      CMD_BLUE:  return TXT_BLUE;
      CMD_ECHO:  return TXT_ECHO;
      CMD_RESET: return TXT_RESET;
      default:   return '0;
    endcase
  endfunction

  // Length 0 for an unknown index: a line of length 0 never reaches matching
  function automatic logic [3:0] cmd_len(input int unsigned idx);
    case (idx)
      CMD_CLEAR: return 4'd5;
      CMD_HELP:  return 4'd4;
      CMD_LED:   return 4'd3;
      CMD_TIME:  return 4'd4;
      CMD_SIREN: return 4'd5;
      CMD_STOP:  return 4'd4;
      CMD_RED:   return 4'd3;
      CMD_GREEN: return 4'd5;
      CMD_BLUE:  return 4'd4;
      CMD_ECHO:  return 4'd4;
      CMD_RESET: return 4'd5;
      default:   return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] text_char(input logic [63:0] txt, input int unsigned pos);
    return txt[63 - 8*pos -: 8];
  endfunction

endpackage

// File: rtl/term_line_buf.sv
// Line buffer: collects printable characters (letters folded to lowercase),
// applies backspace, tracks a sticky overflow flag and flags a line terminator.
module term_line_buf
  import term_cmd_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  input  logic [7:0]               i_data,
  input  logic                     i_clear,
  output logic [MAX_LEN-1:0][7:0]  o_buf,
  output logic [LEN_W-1:0]         o_len,
  output logic                     o_ovf,
  output logic                     o_term
);

  logic [MAX_LEN-1:0][7:0] r_buf;
  logic [LEN_W-1:0]        r_len;
  logic                    r_ovf;

  logic [7:0] w_fold;
  logic       w_print;
  logic       w_bs;
  logic       w_eol;
  logic       w_room;

  // Classify the incoming byte and fold uppercase letters
  always_comb begin
    w_fold  = i_data;
    if (i_data >= 8'h41 && i_data <= 8'h5A) w_fold = i_data + 8'h20;
    w_print = (i_data >= 8'h20) && (i_data <= 8'h7E);
    w_bs    = (i_data == ASCII_BS) || (i_data == ASCII_DEL);
    w_eol   = (i_data == ASCII_CR) || (i_data == ASCII_LF);
    w_room  = (32'(r_len) < MAX_LEN);
    o_term  = i_valid && w_eol && ((r_len != '0) || r_ovf);
  end

  // Length counter and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len <= '0;
      r_ovf <= 1'b0;
    end else if (i_clear) begin
      r_len <= '0;
      r_ovf <= 1'b0;
    end else if (i_valid) begin
      if (w_print) begin
        if (w_room) r_len <= r_len + LEN_W'(1);
        else        r_ovf <= 1'b1;
      end else if (w_bs && (r_len != '0)) begin
        r_len <= r_len - LEN_W'(1);
      end
    end
  end

  // Character storage at the current length position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf <= '0;
    end else if (!i_clear && i_valid && w_print && w_room) begin
      for (int unsigned i = 0; i < MAX_LEN; i++)
        if (32'(r_len) == i) r_buf[i] <= w_fold;
    end
  end

  assign o_buf = r_buf;
  assign o_len = r_len;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/term_cmd_decoder.sv
// Terminal command decoder: buffers a typed line, matches it against the
// command table on a line terminator and drives a held one-hot op_code.
module term_cmd_decoder
  import term_cmd_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CMD_W   = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [CMD_W-1:0] op_code,
  output logic             op_valid,
  output logic             cmd_err,
  output logic             busy
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  state_e r_state;
  state_e w_state_nxt;

  logic                    r_ok;
  logic [CMD_W-1:0]        r_op_code;

  logic [MAX_LEN-1:0][7:0] w_buf;
  logic [LEN_W-1:0]        w_len;
  logic                    w_ovf;
  logic                    w_term;
  logic                    w_accept;
  logic                    w_clear;
  logic [CMD_W-1:0]        w_hit;
  logic                    w_ok;

  function automatic logic line_matches(input logic [MAX_LEN-1:0][7:0] b,
                                        input logic [LEN_W-1:0] len,
                                        input int unsigned k);
    logic eq;
    eq = (32'(len) == 32'(cmd_len(k)));
    for (int unsigned i = 0; i < MAX_LEN; i++)
      if (i < 32'(cmd_len(k)) && b[i] != text_char(cmd_text(k), i)) eq = 1'b0;
    return eq;
  endfunction

  term_line_buf #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_line_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_accept),
    .i_data  (rx_data),
    .i_clear (w_clear),
    .o_buf   (w_buf),
    .o_len   (w_len),
    .o_ovf   (w_ovf),
    .o_term  (w_term)
  );

  // Parallel compare of the buffered line against every table entry
  always_comb begin
    w_hit = '0;
    for (int unsigned k = 0; k < CMD_W; k++)
      w_hit[k] = line_matches(w_buf, w_len, k);
    w_ok = (w_hit != '0) && !w_ovf;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_COLLECT;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_COLLECT: if (w_term) w_state_nxt = ST_MATCH;
      ST_MATCH:   w_state_nxt = ST_ISSUE;
      ST_ISSUE:   w_state_nxt = ST_COLLECT;
      default:    w_state_nxt = ST_COLLECT;
    endcase
  end

  // Output and control decode
  always_comb begin
    busy     = (r_state != ST_COLLECT);
    w_accept = rx_valid && (r_state == ST_COLLECT);
    w_clear  = (r_state == ST_ISSUE);
    op_valid = (r_state == ST_ISSUE) && r_ok;
    cmd_err  = (r_state == ST_ISSUE) && !r_ok;
  end

  // Match result is captured leaving MATCH; op_code loads on that same edge
  // so it is already valid in the ISSUE cycle that pulses op_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ok      <= 1'b0;
      r_op_code <= '0;
    end else if (r_state == ST_MATCH) begin
      r_ok <= w_ok;
      if (w_ok) r_op_code <= w_hit;
    end
  end

  assign op_code = r_op_code;

endmodule

// File: tb/tb_term_cmd_decoder.sv
// Self-checking bench for term_cmd_decoder: directed table, hand-written
// corner sequences and random bytes against a line-level reference model.
module tb_term_cmd_decoder;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CMD_W   = 11;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [CMD_W-1:0] op_code;
  logic             op_valid;
  logic             cmd_err;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int v_cnt  = 0;
  int e_cnt  = 0;

  string names [11] = '{"clear", "help", "led", "time", "siren", "stop",
                        "red", "green", "blue", "echo", "reset"};

  typedef struct {
    string            txt;
    logic [CMD_W-1:0] code;
    int               nv;
    int               ne;
  } vec_t;

  vec_t tbl[$];

  // Reference model state: the line as a queue of characters
  logic [7:0]       m_line[$];
  bit               m_ovf  = 0;
  int               m_wait = 0;
  bit               m_ok   = 0;
  logic [CMD_W-1:0] m_hit  = '0;
  logic [CMD_W-1:0] m_code = '0;

  always #5 clk = ~clk;

  term_cmd_decoder #(.MAX_LEN(MAX_LEN), .CMD_W(CMD_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .op_code  (op_code),
    .op_valid (op_valid),
    .cmd_err  (cmd_err),
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int lookup();
    for (int k = 0; k < 11; k++) begin
      if (names[k].len() == m_line.size()) begin
        bit same = 1;
        for (int i = 0; i < m_line.size(); i++)
          if (names[k].getc(i) != m_line[i]) same = 0;
        if (same) return k;
      end
    end
    return -1;
  endfunction

  // One clock edge of the model: line editing, then a two-cycle issue window
  task automatic model_edge();
    logic [7:0] b;
    int k;
    if (!rst_n) begin
      m_line.delete(); m_ovf = 0; m_wait = 0; m_ok = 0; m_code = '0;
      return;
    end
    if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 1 && m_ok) m_code = m_hit;
    end else if (rx_valid) begin
      b = rx_data;
      if (b >= 8'h41 && b <= 8'h5A) b = b + 8'h20;
      if (b >= 8'h20 && b <= 8'h7E) begin
        if (m_line.size() < MAX_LEN) m_line.push_back(b);
        else m_ovf = 1;
      end else if (b == 8'h08 || b == 8'h7F) begin
        if (m_line.size() > 0) void'(m_line.pop_back());
      end else if (b == 8'h0D || b == 8'h0A) begin
        if (m_line.size() > 0 || m_ovf) begin
          k = lookup();
          m_ok  = (k >= 0) && !m_ovf;
          m_hit = (k >= 0) ? (CMD_W'(1) << k) : '0;
          m_line.delete();
          m_ovf  = 0;
          m_wait = 2;
        end
      end
    end
  endtask

  // Per-cycle comparison of all outputs against the model
  initial begin
    forever begin
      @(posedge clk);
      model_edge();
      #1;
      if (op_valid) v_cnt++;
      if (cmd_err)  e_cnt++;
      chk("cycle_outputs", {op_code, op_valid, cmd_err, busy},
          {m_code, (m_wait == 1) && m_ok, (m_wait == 1) && !m_ok, m_wait > 0});
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic send_str(input string s);
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = s.getc(i);
      send(c);
      if (c == 8'h0D || c == 8'h0A) idle(3);
    end
    idle(1);
  endtask

  task automatic add(input string t, input logic [CMD_W-1:0] c, input int nv, input int ne);
    vec_t v;
    v.txt = t; v.code = c; v.nv = nv; v.ne = ne;
    tbl.push_back(v);
  endtask

  initial begin
    int v0, e0, k, w;
    logic [7:0] c;
    string s;

    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #2;
    chk("reset_state", {op_code, op_valid, cmd_err, busy}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    add("siren\015",                    11'h010, 1, 0);
    add("stop\012",                     11'h020, 1, 0);
    add("SiReN\015\012",                11'h010, 1, 0);
    add("sirx\010en\015",               11'h010, 1, 0);
    add("\010red\015",                  11'h040, 1, 0);
    add("sirens\015",                   11'h040, 0, 1);
    add("aaaaaaaaa\015",                11'h040, 0, 1);
    add("sirenaaaa\010\010\010\010\015", 11'h040, 0, 1);
    add("sire\015",                     11'h040, 0, 1);
    add("\015",                         11'h040, 0, 0);
    add("clear\177\177ar\015",          11'h001, 1, 0);
    add("HELP\015",                     11'h002, 1, 0);
    add("time\015",                     11'h008, 1, 0);
    add("Green\015",                    11'h080, 1, 0);
    add("blue\015",                     11'h100, 1, 0);
    add("echo\015",                     11'h200, 1, 0);
    add("reset\015",                    11'h400, 1, 0);
    add("reset\015",                    11'h400, 1, 0);
    add("led \015",                     11'h400, 0, 1);
    add("led\015",                      11'h004, 1, 0);

    foreach (tbl[i]) begin
      v0 = v_cnt; e0 = e_cnt;
      send_str(tbl[i].txt);
      idle(2);
      chk($sformatf("tbl%0d_code", i),  32'(op_code),  32'(tbl[i].code));
      chk($sformatf("tbl%0d_valid", i), 32'(v_cnt - v0), 32'(tbl[i].nv));
      chk($sformatf("tbl%0d_err", i),   32'(e_cnt - e0), 32'(tbl[i].ne));
    end

    // Byte arriving in the MATCH cycle is dropped
    send_str("stop");
    send(8'h0D);
    send("x");
    #1;
    chk("busy_in_match", 32'(busy), 32'h1);
    idle(3);
    send_str("help\015");
    idle(2);
    chk("help_after_drop", 32'(op_code), 32'h002);

    // Async reset mid-line clears op_code without a clock edge
    send_str("siren\015");
    idle(2);
    chk("siren_before_rst", 32'(op_code), 32'h010);
    send_str("sir");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_midline", {op_code, op_valid, cmd_err, busy}, 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_str("led\015");
    idle(2);
    chk("led_after_rst", 32'(op_code), 32'h004);

    // Async reset while in MATCH discards the pending command
    send_str("echo");
    send(8'h0D);
    idle(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_match", {op_code, op_valid, cmd_err, busy}, 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(4);
    chk("no_issue_after_rst", 32'(op_code), 32'h0);

    // Random byte stream against the model
    for (int n = 0; n < 1500; n++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2: begin
          w = $urandom_range(0, 10);
          s = names[w];
          for (int i = 0; i < s.len(); i++) begin
            c = s.getc(i);
            if ($urandom_range(0, 1) == 1) c = c - 8'h20;
            send(c);
          end
        end
        3:       send(($urandom_range(0, 1) == 1) ? 8'h08 : 8'h7F);
        4, 5:    send(($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A);
        6:       send(8'($urandom_range(32, 126)));
        7:       send(8'($urandom_range(0, 255)));
        default: send(8'($urandom_range(97, 122)));
      endcase
      idle($urandom_range(0, 2));
    end
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
